// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types for the arbitrating multiplexer family.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbitration policy selector
  typedef enum logic {
    ARB_FIXED = 1'b0,  // lowest requesting index always wins
    ARB_RR    = 1'b1   // rotating priority starting after the last winner
  } arb_mode_e;

  // Width of a channel index; a single channel still gets a 1-bit index
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational grant selection over NUM_CH requests with a
//               registered round-robin pointer. In fixed mode the search
//               always starts at index 0 and the pointer is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int        NUM_CH = 4,
  parameter arb_mode_e MODE   = ARB_RR,
  parameter int        CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] start;
  logic            found;
  int              idx;

  // Search the requests from the start index, wrapping once around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    start     = (MODE == ARB_RR) ? ptr_q : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end
    end
  end

  // Pointer moves to the channel after the winner, only when a beat loads
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_rr
// Description : N-channel arbitrating multiplexer with valid/ready handshakes
//               and a single registered output stage. A new beat may load in
//               the same cycle the held beat drains, giving full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux_rr
  import arb_pkg::*;
#(
  parameter int        NUM_CH = 4,
  parameter int        DATA_W = 8,
  parameter arb_mode_e MODE   = ARB_RR,
  parameter int        CH_W   = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        in_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] in_data_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  input  logic                     out_ready_i
);

  logic              load;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [DATA_W-1:0] sel_data;

  // Load when someone requests and the output slot is empty or draining;
  // reset blocks acceptance so no beat is lost while the register clears
  always_comb begin
    load       = (|in_valid_i) && (!out_valid_o || out_ready_i) && !reset_i;
    in_ready_o = load ? grant : '0;
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE),
    .CH_W   (CH_W)
  ) u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req       (in_valid_i),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // AND-OR payload mux driven by the one-hot grant
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        sel_data = sel_data | in_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Output register: load replaces, drain without load empties, else hold
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else if (load) begin
      out_valid_o <= 1'b1;
      out_data_o  <= sel_data;
      out_ch_o    <= grant_idx;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux_rr
// Description : Scoreboard bench for arb_mux_rr. One round-robin and one
//               fixed-priority instance run side by side, each with its own
//               sources, reference model, expected-beat queue and monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux_rr;
  import arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] in_valid  [2];
  logic [31:0] in_data  [2];
  logic       out_ready [2];
  logic [3:0] in_ready  [2];
  logic       out_valid [2];
  logic [7:0] out_data  [2];
  logic [1:0] out_ch    [2];
  logic [3:0] acc       [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit log_en = 1'b0;
  int log_ch [2][16];
  int log_n  [2];

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp);
    end
  endtask

  // First requesting channel found scanning upward from start, wrapping
  function automatic int pick(input logic [3:0] v, input int start);
    for (int i = 0; i < 4; i++) begin
      if (v[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    arb_mux_rr #(
      .NUM_CH (4),
      .DATA_W (8),
      .MODE   (d == 0 ? ARB_RR : ARB_FIXED)
    ) u_dut (
      .clk_i       (clk),
      .reset_i     (rst),
      .in_valid_i  (in_valid[d]),
      .in_data_i   (in_data[d]),
      .in_ready_o  (in_ready[d]),
      .out_valid_o (out_valid[d]),
      .out_data_o  (out_data[d]),
      .out_ch_o    (out_ch[d]),
      .out_ready_i (out_ready[d])
    );

    int q[$];
    int mptr   = 0;
    bit mvalid = 1'b0;

    // Reference model: predicts acceptance and queues expected output beats
    always @(negedge clk) begin
      int g;
      bit load;
      logic [3:0] exp_rdy;
      acc[d] = in_ready[d];
      chk("out_valid", d, int'(out_valid[d]), int'(mvalid));
      if (rst) begin
        chk("in_ready_rst", d, int'(in_ready[d]), 0);
        mvalid = 1'b0;
        mptr   = 0;
        q.delete();
      end else begin
        load    = (in_valid[d] != 4'b0) && (!mvalid || out_ready[d]);
        g       = pick(in_valid[d], (d == 0) ? mptr : 0);
        exp_rdy = load ? 4'(1 << g) : 4'b0;
        chk("in_ready", d, int'(in_ready[d]), int'(exp_rdy));
        if (load) begin
          q.push_back(g * 256 + int'(in_data[d][g*8 +: 8]));
          mvalid = 1'b1;
          mptr   = (g + 1) % 4;
        end else if (out_ready[d]) begin
          mvalid = 1'b0;
        end
      end
    end

    // Monitor: every output transfer must match the oldest expected beat
    always @(negedge clk) begin
      if (!rst && out_valid[d] && out_ready[d]) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty dut%0d: got beat ch %0d data %0h, expected none",
                   d, out_ch[d], out_data[d]);
        end else begin
          int e;
          e = q.pop_front();
          chk("out_ch", d, int'(out_ch[d]), e / 256);
          chk("out_data", d, int'(out_data[d]), e % 256);
          if (log_en && log_n[d] < 16) begin
            log_ch[d][log_n[d]] = int'(out_ch[d]);
            log_n[d]++;
          end
        end
      end
    end
  end

  // Sources drop a beat once it has been accepted
  task automatic consume();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        if (acc[d][k]) in_valid[d][k] = 1'b0;
  endtask

  // rdy: 0 = hold low, 1 = hold high, 2 = random
  task automatic run(input int n, input logic [3:0] mask, input bit rnd,
                     input logic [7:0] base, input int rdy);
    repeat (n) begin
      @(posedge clk);
      #1;
      consume();
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          if (!in_valid[d][k] && mask[k] && (!rnd || $urandom_range(1, 0) == 1)) begin
            in_valid[d][k] = 1'b1;
            in_data[d][k*8 +: 8] = rnd ? 8'($urandom) : base + 8'(k);
          end
        end
        out_ready[d] = (rdy == 2) ? 1'($urandom_range(1, 0)) : (rdy == 1);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 4'b0;
      out_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    consume();
    rst = 1'b1;
    @(posedge clk);
    #1;
    consume();
    rst = 1'b0;
  endtask

  task automatic log_start();
    log_n[0] = 0;
    log_n[1] = 0;
    log_en   = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 4'b0;
      in_data[d]   = 32'b0;
      out_ready[d] = 1'b0;
      acc[d]       = 4'b0;
      log_n[d]     = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_data", d, int'(out_data[d]), 0);
      chk("rst_ch", d, int'(out_ch[d]), 0);
    end

    // Reset in the middle of a busy stream
    run(6, 4'hF, 1'b0, 8'hA0, 1);
    pulse_reset();
    log_start();
    run(3, 4'hF, 1'b0, 8'hA0, 1);
    log_en = 1'b0;
    chk("rst_first_n", 0, int'(log_n[0] >= 1), 1);
    chk("rst_first_grant", 0, log_ch[0][0], 0);

    // All channels busy: rotation in RR, ch0 always in fixed
    do_reset();
    log_start();
    run(10, 4'hF, 1'b0, 8'hA0, 1);
    log_en = 1'b0;
    chk("rr_seq_n", 0, int'(log_n[0] >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      chk("rr_seq", 0, log_ch[0][i], i % 4);
      chk("fix_seq", 1, log_ch[1][i], 0);
    end

    // Sparse requests on ch1 and ch3
    do_reset();
    log_start();
    run(8, 4'b1010, 1'b0, 8'h10, 1);
    log_en = 1'b0;
    chk("sparse_n", 0, int'(log_n[0] >= 3), 1);
    chk("sparse0", 0, log_ch[0][0], 1);
    chk("sparse1", 0, log_ch[0][1], 3);
    chk("sparse2", 0, log_ch[0][2], 1);
    chk("sparse_fix", 1, log_ch[1][1], 1);

    // ch0 idle: fixed starves ch2/ch3, RR rotates over 1..3
    do_reset();
    log_start();
    run(8, 4'b1110, 1'b0, 8'h40, 1);
    log_en = 1'b0;
    chk("fix_n", 1, int'(log_n[1] >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      chk("fix_starve", 1, log_ch[1][i], 1);
      chk("rr_skip0", 0, log_ch[0][i], (i % 3) + 1);
    end

    // Backpressure with a waiting beat on ch2
    do_reset();
    log_start();
    run(1, 4'b0100, 1'b0, 8'h5A, 0);
    run(3, 4'b0100, 1'b0, 8'h5A, 0);
    for (int d = 0; d < 2; d++) begin
      chk("bp_valid", d, int'(out_valid[d]), 1);
      chk("bp_data", d, int'(out_data[d]), 8'h5C);
      chk("bp_ch", d, int'(out_ch[d]), 2);
      chk("bp_ready", d, int'(in_ready[d]), 0);
    end
    run(4, 4'b0100, 1'b0, 8'h5A, 1);
    log_en = 1'b0;
    chk("bp_n", 0, int'(log_n[0] >= 3), 1);
    chk("bp_first", 0, log_ch[0][0], 2);

    // Single beat drains to idle, then pointer must sit at ch1
    do_reset();
    log_start();
    run(1, 4'b0001, 1'b0, 8'h77, 1);
    run(4, 4'b0000, 1'b0, 8'h00, 1);
    for (int d = 0; d < 2; d++) begin
      chk("idle_valid", d, int'(out_valid[d]), 0);
      chk("idle_data", d, int'(out_data[d]), 8'h77);
      chk("idle_ch", d, int'(out_ch[d]), 0);
    end
    run(3, 4'hF, 1'b0, 8'hA0, 1);
    log_en = 1'b0;
    chk("idle_n", 0, int'(log_n[0] >= 2), 1);
    chk("idle_first", 0, log_ch[0][0], 0);
    chk("idle_ptr", 0, log_ch[0][1], 1);

    // Random arrivals, payloads and backpressure
    for (int r = 0; r < 4; r++) begin
      do_reset();
      run(150, 4'hF, 1'b1, 8'h00, 2);
    end
    run(6, 4'h0, 1'b0, 8'h00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_mux_rr.md
Name: arb_mux_rr

Overview:
Parametrised N-channel arbitrating multiplexer with valid/ready handshakes, the sequential successor of the team's 4:1 one-hot/priority mux. It selects one of N requesting input channels and forwards its W-bit payload through a single registered output stage. It supports fixed-priority mode (lowest index wins) and round-robin mode. It sits in front of any shared single-consumer resource (bus port, shared FIFO write side).

Parameters:
NUM_CH, 4, number of input channels (>=1)
DATA_W, 8, payload width per channel
MODE, ARB_RR, arbitration mode (arb_pkg::arb_mode_e: ARB_FIXED or ARB_RR)
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), derived; width of channel index; not overridden

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  synchronous, active-high reset
in_valid_i  input  NUM_CH  per-channel request/valid
in_data_i  input  NUM_CH*DATA_W  packed payloads; channel k at [k*DATA_W +: DATA_W]
in_ready_o  output  NUM_CH  per-channel accept; one-hot or zero
out_valid_o  output  1  output register holds a beat
out_data_o  output  DATA_W  registered payload
out_ch_o  output  CH_W  index of the channel that supplied out_data_o
out_ready_i  input  1  downstream accept

Behaviour:
- Reset (reset_i=1 at a rising edge): out_valid_o=0, out_data_o=0, out_ch_o=0, RR pointer=0. in_ready_o=0 while reset_i=1. A beat held in the output register is dropped, no error flagged.
- Transfer definitions: input beat on channel k when in_valid_i[k] & in_ready_o[k]; output beat when out_valid_o & out_ready_i.
- load = (|in_valid_i) & (!out_valid_o | out_ready_i). Full throughput: one beat per cycle when out_ready_i is held at 1.
- Grant (combinational, from in_valid_i and pointer):
  - ARB_FIXED: lowest index k with in_valid_i[k]=1.
  - ARB_RR: first k with in_valid_i[k]=1, searching ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1.
- in_ready_o = load ? onehot(grant) : 0. Never more than one bit set.
- On load edge: out_data_o<=in_data_i[grant], out_ch_o<=grant, out_valid_o<=1. Latency: input beat to out_valid_o is 1 cycle.
- When out_ready_i=1 and no load: out_valid_o<=0. out_data_o/out_ch_o hold their last values.
- While out_valid_o & !out_ready_i: out_valid_o, out_data_o, out_ch_o are stable, and in_ready_o=0.
- RR pointer: updates only on load: ptr<=(grant==NUM_CH-1)?0:grant+1. The pointer is unused in ARB_FIXED mode.
- Simultaneous output drain and new load in the same cycle: new beat replaces old, and out_valid_o stays 1 (no bubble).
- No valids: nothing loads, and the pointer does not move.
- NUM_CH=1: grant is always 0, out_ch_o=0, and the block behaves as a 1-deep pipeline register.
- Input sources must keep in_valid_i/in_data_i stable until accepted. The block does not check this.
- Fairness (ARB_RR): with all channels continuously valid and out_ready_i=1, each channel is granted exactly once in any NUM_CH consecutive loads.

Decomposition:
- Package arb_pkg: typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e.
- Sub-module rr_arbiter (NUM_CH, MODE):
  - inputs: clk_i, reset_i, req, advance
  - outputs: one-hot grant, grant index
  - holds the RR pointer
- arb_mux_rr contains the load logic, the payload mux and the output register.

Test Plan:
1. Reset mid-stream: MODE=ARB_RR, all valid, out_ready_i=1, assert reset_i for 1 cycle. Required response: next cycle out_valid_o=0, in_ready_o=0. After release, the first grant is ch0.
2. RR fairness: NUM_CH=4, in_valid_i=4'b1111, out_ready_i=1, data k=8'hA0+k for 8 cycles. Required response: out_ch_o sequence 0,1,2,3,0,1,2,3 and out_data_o A0,A1,A2,A3,...
3. Sparse RR: ptr=0, in_valid_i=4'b1010. Required response: grant ch1, then ch3, then ch1; ch0 and ch2 never get in_ready_o.
4. Fixed priority: MODE=ARB_FIXED, in_valid_i=4'b1110 held. Required response: out_ch_o=1 every beat, and ch2/ch3 are starved.
5. Backpressure: one beat on ch2 (data 8'h5C), out_ready_i=0 for 3 cycles. Required response: out_valid_o=1, out_data_o=5C, out_ch_o=2 stable, in_ready_o=0. Release → beat accepted, and next load happens in the same cycle.
6. Drain to idle: single beat on ch0, then in_valid_i=0, out_ready_i=1. Required response: out_valid_o is 1 for exactly one cycle, out_data_o holds, and the pointer stays 1.
